mac_matmul_seq: RTL
===================

Name: mac_matmul_seq

Overview:
Sequencer that computes C = A x B with a single mac unit. It reads A (M x K) and B (K x N) from synchronous 1-cycle-latency operand RAMs and streams K contiguous operand pairs per output element. It drives acc_clear at the correct cycle, captures the finished dot product and emits each C element in row-major order over a valid/ready port. The block sits between the operand buffers, the mac instance (wired alongside it at top level) and the result sink.

Parameters:
DATA_W, 16, operand width; must equal mac DATA_W
M, 4, rows of A and C
K, 4, inner dimension; must equal mac K; K >= 1
N, 4, columns of B and C
ACC_W, derived (localparam), 2*DATA_W + $clog2(K) + 1; matches mac output width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin a matrix multiply; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last C handshake
err  out  1  sticky; mac valid missing at the expected capture cycle; cleared by accepted start
a_rd_addr  out  max(1,$clog2(M*K))  A address, row-major i*K+k
a_rd_data  in  DATA_W  signed A data, one cycle after address
b_rd_addr  out  max(1,$clog2(K*N))  B address, row-major k*N+j
b_rd_data  in  DATA_W  signed B data, one cycle after address
mac_a  out  DATA_W  to mac a_in
mac_b  out  DATA_W  to mac b_in
mac_acc_clear  out  1  to mac acc_clear
mac_acc_out  in  ACC_W  from mac acc_out
mac_acc_out_valid  in  1  from mac acc_out_valid
c_valid  out  1  result valid
c_ready  in  1  sink ready
c_addr  out  max(1,$clog2(M*N))  row-major i*N+j
c_data  out  ACC_W  signed dot-product result

Behaviour:
- Reset values: state = IDLE. busy, done, err, c_valid and mac_acc_clear are 0. All addresses, mac_a, mac_b, c_addr and c_data are 0. Reset mid-operation aborts immediately with no done pulse; the mac shares rst.
- FSM states: IDLE, ISSUE, DRAIN, WRITE.
- IDLE: start=1 moves to ISSUE with i = j = k = 0; clears err.
- ISSUE: runs K cycles, t0..t(K-1).
  - Cycle tk drives a_rd_addr = i*K+k and b_rd_addr = k*N+j.
  - A registered issue-valid pipeline forwards RAM data: mac_a/mac_b = a/b_rd_data in cycles t1..tK, 0 otherwise.
  - mac_acc_clear = 1 for exactly cycle t2 (issue of k=0, delayed 2 cycles). This holds for K = 1 too.
- After ISSUE, go to DRAIN.
- DRAIN: the capture cycle is t(K+2).
  - If mac_acc_out_valid = 1 in that cycle, register c_data = mac_acc_out and c_addr = i*N+j, and set c_valid.
  - Otherwise set err and capture anyway.
  - Then go to WRITE.
- WRITE: hold c_valid, c_data and c_addr stable until c_valid & c_ready.
  - On the handshake, advance j, wrapping to 0 with i+1.
  - If the element was (M-1, N-1), pulse done and return to IDLE (busy drops the same cycle done pulses). Otherwise return to ISSUE next cycle.
- Operand pairs are never stalled, because the mac accumulates every cycle. Backpressure acts only in WRITE, before the next ISSUE.
- Throughput with c_ready = 1: K+4 cycles per element. The first c_valid rises in cycle t(K+3).
- start while busy is ignored.
- No arithmetic is done in this block; results pass through at full ACC_W and cannot overflow.

Decomposition:
- Package mac_pkg holds:
  - function acc_w(data_w, k), shared with mac;
  - the enum typedef seq_state_e {IDLE, ISSUE, DRAIN, WRITE};
  - function addr_w(depth) returning max(1, $clog2(depth)).
- One natural sub-module, mac_idx_cnt: nested i/j/k counters with wrap/last flags and row-major address generation. The FSM, delay pipeline and result register stay in mac_matmul_seq.
- The bench instantiates mac, both RAM models and this block.

Test Plan:
- Identity times ramp: A = I4, B = 1..16 row-major, c_ready = 1 → C = 1..16 in c_addr order 0..15. First c_valid at t7. Element period 8 cycles. done exactly once, at t128. err = 0.
- Signed extremes: A and B all -32768 → every c_data = 4294967296. Then A all 32767, B all -32768 → every c_data = -4294836224.
- Backpressure: c_ready low for 5 cycles at element 2 → c_valid, c_data and c_addr stay stable. No address changes occur. Element 3 ISSUE starts the cycle after the handshake. Final C is identical to the unstalled run.
- start pulsed mid-run, at element 5 → ignored, with no change in sequence or count. A new start after done re-runs and produces identical C.
- rst asserted during DRAIN of element 9 → next cycle all outputs are 0, state is IDLE, no done. A fresh start then gives correct full C.
- Config M=2, K=1, N=3 with A = [2,-3]^T and B = [1,5,7] → C = 2,10,14,-3,-15,-21. Element period is 5 cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: types and width helpers shared by the matmul sequencer and the mac.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE
  } seq_state_e;

  // Accumulator width: full product plus enough headroom for k additions and sign.
  function automatic int acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_idx_cnt.sv
// mac_idx_cnt: nested i/j/k loop counters for the matmul sequencer together
// with the row-major A, B and C addresses derived from them.
module mac_idx_cnt
  import mac_pkg::*;
#(
  parameter int M = 4,
  parameter int K = 4,
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    k_inc,
  input  logic                    j_inc,
  output logic                    k_first,
  output logic                    k_last,
  output logic                    elem_last,
  output logic [addr_w(M*K)-1:0]  a_addr,
  output logic [addr_w(K*N)-1:0]  b_addr,
  output logic [addr_w(M*N)-1:0]  c_addr
);

  localparam int IW  = addr_w(M);
  localparam int JW  = addr_w(N);
  localparam int KW  = addr_w(K);
  localparam int AAW = addr_w(M * K);
  localparam int BAW = addr_w(K * N);
  localparam int CAW = addr_w(M * N);

  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          i_last, j_last;

  assign k_first   = (k_q == '0);
  assign k_last    = (k_q == KW'(K - 1));
  assign j_last    = (j_q == JW'(N - 1));
  assign i_last    = (i_q == IW'(M - 1));
  assign elem_last = i_last & j_last;

  // Next-index logic: k walks the inner dimension; a result handshake steps j, then i.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      if (k_inc) begin
        k_d = k_last ? '0 : k_q + 1'b1;
      end
      if (j_inc) begin
        if (j_last) begin
          j_d = '0;
          i_d = i_last ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  assign a_addr = AAW'(32'(i_q) * K + 32'(k_q));
  assign b_addr = BAW'(32'(k_q) * N + 32'(j_q));
  assign c_addr = CAW'(32'(i_q) * N + 32'(j_q));

endmodule

// File: rtl/mac_matmul_seq.sv
// mac_matmul_seq: drives one external mac through C = A x B, streaming K
// operand pairs per element from 1-cycle-latency RAMs and emitting each
// finished dot product in row-major order over a valid/ready port.
module mac_matmul_seq
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [addr_w(M*K)-1:0]            a_rd_addr,
  input  logic signed [DATA_W-1:0]          a_rd_data,
  output logic [addr_w(K*N)-1:0]            b_rd_addr,
  input  logic signed [DATA_W-1:0]          b_rd_data,
  output logic signed [DATA_W-1:0]          mac_a,
  output logic signed [DATA_W-1:0]          mac_b,
  output logic                              mac_acc_clear,
  input  logic signed [acc_w(DATA_W,K)-1:0] mac_acc_out,
  input  logic                              mac_acc_out_valid,
  output logic                              c_valid,
  input  logic                              c_ready,
  output logic [addr_w(M*N)-1:0]            c_addr,
  output logic signed [acc_w(DATA_W,K)-1:0] c_data
);

  localparam int ACC_W = acc_w(DATA_W, K);
  localparam int CAW   = addr_w(M * N);

  seq_state_e              state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    c_valid_q, c_valid_d;
  logic [CAW-1:0]          c_addr_q, c_addr_d;
  logic signed [ACC_W-1:0] c_data_q, c_data_d;
  logic                    issue_v_q, issue_v_d;
  logic                    first_q, first_d;
  logic                    clear_q, clear_d;
  logic [1:0]              drain_q, drain_d;

  logic                    idx_clr, k_inc, j_inc;
  logic                    k_first, k_last, elem_last;
  logic [CAW-1:0]          c_idx;

  mac_idx_cnt #(
    .M(M),
    .K(K),
    .N(N)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (idx_clr),
    .k_inc    (k_inc),
    .j_inc    (j_inc),
    .k_first  (k_first),
    .k_last   (k_last),
    .elem_last(elem_last),
    .a_addr   (a_rd_addr),
    .b_addr   (b_rd_addr),
    .c_addr   (c_idx)
  );

  // Sequencer next state: issue K pairs, wait for the mac to finish, then hand off the result.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    c_valid_d = c_valid_q;
    c_addr_d  = c_addr_q;
    c_data_d  = c_data_q;
    drain_d   = drain_q;
    idx_clr   = 1'b0;
    k_inc     = 1'b0;
    j_inc     = 1'b0;
    issue_v_d = (state_q == ISSUE);
    first_d   = (state_q == ISSUE) && k_first;
    clear_d   = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          idx_clr = 1'b1;
        end
      end
      ISSUE: begin
        k_inc   = 1'b1;
        drain_d = 2'd0;
        if (k_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          if (!mac_acc_out_valid) begin
            err_d = 1'b1;
          end
          c_data_d  = mac_acc_out;
          c_addr_d  = c_idx;
          c_valid_d = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (c_ready) begin
          c_valid_d = 1'b0;
          j_inc     = 1'b1;
          if (elem_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, result and issue-delay registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      c_valid_q <= 1'b0;
      c_addr_q  <= '0;
      c_data_q  <= '0;
      issue_v_q <= 1'b0;
      first_q   <= 1'b0;
      clear_q   <= 1'b0;
      drain_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      c_valid_q <= c_valid_d;
      c_addr_q  <= c_addr_d;
      c_data_q  <= c_data_d;
      issue_v_q <= issue_v_d;
      first_q   <= first_d;
      clear_q   <= clear_d;
      drain_q   <= drain_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign c_valid       = c_valid_q;
  assign c_addr        = c_addr_q;
  assign c_data        = c_data_q;
  assign mac_acc_clear = clear_q;
  assign mac_a         = issue_v_q ? a_rd_data : '0;
  assign mac_b         = issue_v_q ? b_rd_data : '0;

endmodule
